// File: rtl/tilelink_ul_master.sv
// Single-outstanding TileLink-UL initiator: one request in, Get/Put on channel A, beats collected from channel D.
// Responses are registered, one cycle after each D beat. The response port has no backpressure; req_ready is high only in IDLE.
module tilelink_ul_master #(
  parameter logic SOURCE_ID = 1'b0,
  parameter int   MAX_SIZE  = 6,
  parameter int   TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_wdata,
  input  logic        a_ready,
  output logic        a_valid,
  output logic [2:0]  a_bits_opcode,
  output logic [2:0]  a_bits_param,
  output logic [3:0]  a_bits_size,
  output logic        a_bits_source,
  output logic [31:0] a_bits_address,
  output logic [3:0]  a_bits_mask,
  output logic [31:0] a_bits_data,
  output logic        d_ready,
  input  logic        d_valid,
  input  logic [2:0]  d_bits_opcode,
  input  logic [1:0]  d_bits_param,
  input  logic [3:0]  d_bits_size,
  input  logic        d_bits_source,
  input  logic        d_bits_sink,
  input  logic [1:0]  d_bits_addr_lo,
  input  logic [31:0] d_bits_data,
  input  logic        d_bits_error,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_last,
  output logic        resp_error,
  output logic        stray_d
);

  typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT} state_t;

  state_t      state, state_nxt;
  logic        r_get;
  logic [2:0]  r_opcode;
  logic [3:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_mask;
  logic [31:0] r_data;
  logic [3:0]  r_last_idx;
  logic [3:0]  bcnt;
  logic [15:0] tcnt;

  logic        req_fire, req_bad, a_fire, d_fire, beat_last, d_mismatch, tmo_hit;
  logic [3:0]  get_mask;

  assign a_bits_opcode  = r_opcode;
  assign a_bits_param   = 3'd0;
  assign a_bits_size    = r_size;
  assign a_bits_source  = SOURCE_ID;
  assign a_bits_address = r_addr;
  assign a_bits_mask    = r_mask;
  assign a_bits_data    = r_data;

  assign req_fire   = req_valid & req_ready;
  assign a_fire     = a_valid & a_ready;
  assign d_fire     = d_valid & d_ready;
  assign beat_last  = (bcnt == r_last_idx);
  assign d_mismatch = (d_bits_source != SOURCE_ID) || (d_bits_opcode != (r_get ? 3'd1 : 3'd0));
  assign tmo_hit    = (TIMEOUT != 0) && (state == D_WAIT) && !d_fire &&
                      ((32'(tcnt) + 32'd1) == 32'(TIMEOUT));

  always_comb begin
    req_bad = ((req_addr & ((32'd1 << req_size) - 32'd1)) != 32'd0) ||
              (req_write && (req_size > 4'd2)) ||
              (!req_write && ({28'd0, req_size} > 32'(MAX_SIZE)));
    if (req_size >= 4'd2)      get_mask = 4'hF;
    else if (req_size == 4'd1) get_mask = 4'b0011 << {req_addr[1], 1'b0};
    else                       get_mask = 4'b0001 << req_addr[1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    d_ready   = 1'b0;
    a_valid   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        d_ready   = 1'b1;
        if (req_valid && !req_bad) state_nxt = A_SEND;
      end
      A_SEND: begin
        a_valid = 1'b1;
        if (a_ready) state_nxt = D_WAIT;
      end
      D_WAIT: begin
        d_ready = 1'b1;
        if ((d_fire && beat_last) || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Handshakes are held off for as long as reset is asserted.
    if (reset) begin
      req_ready = 1'b0;
      d_ready   = 1'b0;
      a_valid   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_last  <= 1'b0;
      resp_error <= 1'b0;
      stray_d    <= 1'b0;
      bcnt       <= 4'd0;
      tcnt       <= 16'd0;
      r_get      <= 1'b0;
      r_opcode   <= 3'd0;
      r_size     <= 4'd0;
      r_addr     <= 32'd0;
      r_mask     <= 4'd0;
      r_data     <= 32'd0;
      r_last_idx <= 4'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_last  <= 1'b0;
      resp_error <= 1'b0;
      if (req_fire) begin
        if (req_bad) begin
          resp_valid <= 1'b1;
          resp_error <= 1'b1;
          resp_last  <= 1'b1;
        end else begin
          r_get      <= !req_write;
          r_opcode   <= !req_write ? 3'd4 :
                        ((req_size == 4'd2) && (req_mask == 4'hF)) ? 3'd0 : 3'd1;
          r_size     <= req_size;
          r_addr     <= req_addr;
          r_mask     <= req_write ? req_mask : get_mask;
          r_data     <= req_wdata;
          // Index of the final beat: a 2^size byte Get spans 2^(size-2) words.
          r_last_idx <= (!req_write && (req_size > 4'd2)) ?
                        ((4'd1 << (req_size - 4'd2)) - 4'd1) : 4'd0;
        end
      end
      if ((state == IDLE) && d_fire) stray_d <= 1'b1;
      if (a_fire) begin
        bcnt <= 4'd0;
        tcnt <= 16'd0;
      end
      if (state == D_WAIT) begin
        if (d_fire) begin
          resp_valid <= 1'b1;
          resp_rdata <= d_bits_data;
          resp_error <= d_bits_error | d_mismatch;
          resp_last  <= beat_last;
          bcnt       <= bcnt + 4'd1;
          tcnt       <= 16'd0;
        end else if (tmo_hit) begin
          resp_valid <= 1'b1;
          resp_error <= 1'b1;
          resp_last  <= 1'b1;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tilelink_ul_master.sv
// Randomized scoreboard bench for tilelink_ul_master with an in-bench slave and reference model.
module tb_tilelink_ul_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [3:0]  req_size = 4'd0, req_mask = 4'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready;
  logic        a_ready = 1'b0;
  logic        a_valid;
  logic [2:0]  a_bits_opcode, a_bits_param;
  logic [3:0]  a_bits_size, a_bits_mask;
  logic        a_bits_source;
  logic [31:0] a_bits_address, a_bits_data;
  logic        d_ready;
  logic        d_valid = 1'b0;
  logic [2:0]  d_bits_opcode = 3'd0;
  logic [1:0]  d_bits_param = 2'd0, d_bits_addr_lo = 2'd0;
  logic [3:0]  d_bits_size = 4'd0;
  logic        d_bits_source = 1'b0, d_bits_sink = 1'b0, d_bits_error = 1'b0;
  logic [31:0] d_bits_data = 32'd0;
  logic        resp_valid, resp_last, resp_error, stray_d;
  logic [31:0] resp_rdata;

  tilelink_ul_master #(.SOURCE_ID(1'b0), .MAX_SIZE(6), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .a_ready(a_ready), .a_valid(a_valid), .a_bits_opcode(a_bits_opcode),
    .a_bits_param(a_bits_param), .a_bits_size(a_bits_size), .a_bits_source(a_bits_source),
    .a_bits_address(a_bits_address), .a_bits_mask(a_bits_mask), .a_bits_data(a_bits_data),
    .d_ready(d_ready), .d_valid(d_valid), .d_bits_opcode(d_bits_opcode),
    .d_bits_param(d_bits_param), .d_bits_size(d_bits_size), .d_bits_source(d_bits_source),
    .d_bits_sink(d_bits_sink), .d_bits_addr_lo(d_bits_addr_lo), .d_bits_data(d_bits_data),
    .d_bits_error(d_bits_error),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_last(resp_last),
    .resp_error(resp_error), .stray_d(stray_d)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        last;
    logic        err;
    logic        chk_data;
  } resp_t;

  typedef struct {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        put;
  } areq_t;

  resp_t exp_q[$];
  areq_t a_q[$];
  int total = 0;
  int bad   = 0;

  // Slave behaviour knobs, set per transaction.
  int gap_beat, gap_len, deliver, a_dly;
  bit rand_gaps, rand_err, bad_src, expect_tmo;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic knobs_default();
    gap_beat = -1; gap_len = 0; deliver = -1; a_dly = 0;
    rand_gaps = 0; rand_err = 0; bad_src = 0; expect_tmo = 0;
  endtask

  // Reference model, from the transfer rules: alignment, size limits, byte lanes.
  function automatic bit m_legal(input logic wr, input logic [3:0] sz, input logic [31:0] addr);
    longint unsigned bytes = longint'(1) << sz;
    if ((longint'(addr) % bytes) != 0) return 0;
    if (wr) return (sz <= 2);
    return (sz <= 6);
  endfunction

  function automatic int m_beats(input logic wr, input logic [3:0] sz);
    int words;
    if (wr) return 1;
    words = (1 << sz) / 4;
    return (words < 1) ? 1 : words;
  endfunction

  function automatic logic [3:0] m_mask(input logic wr, input logic [3:0] sz,
                                        input logic [31:0] addr, input logic [3:0] msk);
    int lanes;
    if (wr) return msk;
    if (sz >= 2) return 4'hF;
    lanes = ((1 << (1 << sz)) - 1) << addr[1:0];
    return 4'(lanes);
  endfunction

  task automatic txn(input logic wr, input logic [3:0] sz, input logic [31:0] addr,
                     input logic [3:0] msk, input logic [31:0] wd);
    int    nb, nd, g, w;
    areq_t ea;
    resp_t er;
    logic  derr, src, want_op;
    logic  [2:0] op;
    logic  [31:0] dat;
    if (!m_legal(wr, sz, addr)) begin
      er.rdata = 32'd0; er.last = 1'b1; er.err = 1'b1; er.chk_data = 1'b1;
      exp_q.push_back(er);
    end else begin
      ea.opcode = !wr ? 3'd4 : ((sz == 2) && (msk == 4'hF)) ? 3'd0 : 3'd1;
      ea.size = sz; ea.addr = addr; ea.mask = m_mask(wr, sz, addr, msk);
      ea.data = wd; ea.put = wr;
      a_q.push_back(ea);
    end
    req_write = wr; req_size = sz; req_addr = addr; req_mask = msk; req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clock);
    check("req_ready_idle", req_ready, 1'b1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (!m_legal(wr, sz, addr)) begin
      @(negedge clock);
      @(posedge clock); #1;
      return;
    end
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (!a_valid && w < 10);
    if (!a_valid) begin
      total++; bad++;
      $display("FAIL a_valid_wait got=0 exp=1 within 10 cycles");
      a_q.delete();
      return;
    end
    @(posedge clock); #1;
    repeat (a_dly) begin @(posedge clock); #1; end
    a_ready = 1'b1;
    @(posedge clock); #1;
    a_ready = 1'b0;
    nb = m_beats(wr, sz);
    nd = (deliver < 0) ? nb : deliver;
    want_op = wr ? 1'b0 : 1'b1;
    if (expect_tmo) begin
      er.rdata = 32'd0; er.last = 1'b1; er.err = 1'b1; er.chk_data = 1'b0;
      exp_q.push_back(er);
    end
    for (int b = 0; b < nd; b++) begin
      g = (b == gap_beat) ? gap_len : (rand_gaps ? int'($urandom_range(0, 3)) : 0);
      repeat (g) begin @(posedge clock); #1; end
      dat  = $urandom;
      derr = rand_err && ($urandom_range(0, 7) == 0);
      src  = bad_src || (rand_err && ($urandom_range(0, 7) == 0));
      op   = (rand_err && ($urandom_range(0, 7) == 0)) ? 3'd2 : {2'b00, want_op};
      er.rdata = dat; er.last = (b == nb - 1); er.chk_data = 1'b1;
      er.err = derr | (src != 1'b0) | (op != {2'b00, want_op});
      exp_q.push_back(er);
      d_valid = 1'b1; d_bits_opcode = op; d_bits_size = sz; d_bits_source = src;
      d_bits_addr_lo = addr[1:0]; d_bits_data = dat; d_bits_error = derr;
      @(negedge clock);
      check("d_ready_dwait", d_ready, 1'b1);
      @(posedge clock); #1;
      d_valid = 1'b0; d_bits_error = 1'b0; d_bits_source = 1'b0;
    end
    if (nd == nb) begin
      @(negedge clock);
      check("req_ready_after_last", req_ready, 1'b1);
      @(posedge clock); #1;
    end else if (expect_tmo) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        check("no_early_timeout", resp_valid, 1'b0);
      end
      @(negedge clock);
      check("timeout_pulse", resp_valid, 1'b1);
      @(posedge clock); #1;
    end else begin
      @(negedge clock);
    end
  endtask

  resp_t mr;
  areq_t ma;
  always @(negedge clock) begin
    if (!reset) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected got rdata=%h err=%b last=%b exp=no pulse",
                   resp_rdata, resp_error, resp_last);
        end else begin
          mr = exp_q.pop_front();
          if (mr.chk_data) check("resp_rdata", resp_rdata, mr.rdata);
          check("resp_last", resp_last, mr.last);
          check("resp_error", resp_error, mr.err);
        end
      end
      if (a_valid) begin
        check("d_ready_in_a_send", d_ready, 1'b0);
        if (a_q.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected got a_valid=1 exp=0 addr=%h", a_bits_address);
        end else begin
          ma = a_q[0];
          check("a_opcode", a_bits_opcode, ma.opcode);
          check("a_param", a_bits_param, 3'd0);
          check("a_size", a_bits_size, ma.size);
          check("a_source", a_bits_source, 1'b0);
          check("a_address", a_bits_address, ma.addr);
          check("a_mask", a_bits_mask, ma.mask);
          if (ma.put) check("a_data", a_bits_data, ma.data);
          if (a_ready) void'(a_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        wr;
    logic [3:0]  sz;
    logic [31:0] ad;
    knobs_default();
    @(negedge clock);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_d_ready", d_ready, 1'b0);
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_stray_d", stray_d, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("idle_req_ready", req_ready, 1'b1);
    check("idle_d_ready", d_ready, 1'b1);
    @(posedge clock); #1;

    knobs_default(); gap_beat = 0; gap_len = 3;
    txn(1'b0, 4'd2, 32'h0001_0000, 4'h0, 32'h0);
    knobs_default(); gap_beat = 2; gap_len = 5;
    txn(1'b0, 4'd4, 32'h0000_0040, 4'h0, 32'h0);
    knobs_default(); a_dly = 2;
    txn(1'b1, 4'd0, 32'h0000_0002, 4'h4, 32'h00AB_0000);
    knobs_default();
    txn(1'b1, 4'd2, 32'h0000_0100, 4'hF, 32'h1234_5678);
    txn(1'b0, 4'd1, 32'h0000_0102, 4'h0, 32'h0);
    txn(1'b0, 4'd6, 32'h0000_0200, 4'h0, 32'h0);
    txn(1'b0, 4'd2, 32'h0000_0002, 4'h0, 32'h0);
    txn(1'b1, 4'd3, 32'h0000_0008, 4'hF, 32'h0);
    txn(1'b0, 4'd7, 32'h0000_0000, 4'h0, 32'h0);

    knobs_default(); deliver = 0; expect_tmo = 1;
    txn(1'b0, 4'd2, 32'h0000_0300, 4'h0, 32'h0);
    check("stray_before", stray_d, 1'b0);
    d_valid = 1'b1; d_bits_opcode = 3'd1; d_bits_data = 32'hCAFE_F00D;
    @(posedge clock); #1;
    d_valid = 1'b0;
    @(negedge clock);
    check("stray_after_late_beat", stray_d, 1'b1);
    @(posedge clock); #1;

    knobs_default(); deliver = 2;
    txn(1'b0, 4'd4, 32'h0000_0400, 4'h0, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("midrst_a_valid", a_valid, 1'b0);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_d_ready", d_ready, 1'b0);
    check("midrst_req_ready", req_ready, 1'b0);
    check("midrst_stray_cleared", stray_d, 1'b0);
    exp_q.delete();
    a_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    knobs_default();
    txn(1'b0, 4'd4, 32'h0000_0500, 4'h0, 32'h0);
    knobs_default(); bad_src = 1;
    txn(1'b0, 4'd2, 32'h0000_0600, 4'h0, 32'h0);

    for (int n = 0; n < 60; n++) begin
      knobs_default(); rand_gaps = 1; rand_err = 1; a_dly = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      sz = wr ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7));
      ad = $urandom & ~((32'd1 << sz) - 32'd1);
      if (sz != 0 && $urandom_range(0, 4) == 0) ad = ad | 32'd1;
      txn(wr, sz, ad, 4'($urandom), $urandom);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    check("a_queue_drained", a_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
